// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Frame states, newline byte and requester ceiling.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } uart_state_e;

  localparam logic [7:0] UART_NL      = 8'h0A;
  localparam int         UART_MAX_REQ = 8;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 frame serializer paced by the baud strobe.
// Holds the SYNC..STOP sequence, bit counter, shift register and tx.
module uart_tx_serializer
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       txclk_en,
  input  logic       load,
  input  logic [7:0] din,
  output logic       tx,
  output logic       busy
);

  uart_state_e state_q, state_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  sh_q, sh_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= '0;
      sh_q     <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      sh_q     <= sh_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  // A strobe in the load cycle is ignored: SYNC waits for the next one.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (load) state_d = ST_SYNC;
      ST_SYNC:  if (txclk_en) state_d = ST_START;
      ST_START: if (txclk_en) state_d = ST_DATA;
      ST_DATA: begin
        if (txclk_en && bitcnt_q == 3'd7) state_d = ST_STOP;
      end
      ST_STOP:  if (txclk_en) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bitcnt_d = bitcnt_q;
    sh_d     = sh_q;
    tx_d     = tx_q;
    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (load) sh_d = din;
      end
      ST_SYNC: begin
        if (txclk_en) tx_d = 1'b0;
      end
      ST_START: begin
        if (txclk_en) begin
          tx_d     = sh_q[0];
          bitcnt_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (txclk_en) begin
          if (bitcnt_q == 3'd7) begin
            tx_d = 1'b1;
          end else begin
            tx_d     = sh_q[3'(bitcnt_q + 3'd1)];
            bitcnt_d = 3'(bitcnt_q + 3'd1);
          end
        end
      end
      ST_STOP: tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  assign busy_d = (state_d != ST_IDLE);
  assign tx     = tx_q;
  assign busy   = busy_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 TX line among NREQ byte sources.
// Define UART_ARB_LINE_LOCK_EN to hold the line for one source until newline.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ         = 2,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              txclk_en,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx,
  output logic              busy,
  output logic [2:0]        grant_id
);

  logic [2:0]      last_q, last_d;
  logic [2:0]      grant_q, grant_d;
  logic [NREQ-1:0] cand;
  logic [2:0]      win;
  logic            win_vld;
  logic            idle;
  logic            xfer;
  logic [7:0]      din;
  logic            ser_busy;

`ifdef UART_ARB_LINE_LOCK_EN
  logic            lock_q, lock_d;
  logic [2:0]      lock_id_q, lock_id_d;
  logic [31:0]     tcnt_q, tcnt_d;
  logic [NREQ-1:0] lock_mask;

  always_comb begin
    lock_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      lock_mask[i] = (lock_id_q == 3'(i));
    end
  end

  assign cand = lock_q ? (req_valid & lock_mask) : req_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      tcnt_q    <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      tcnt_q    <= tcnt_d;
    end
  end

  // Idle strobes only count while the owner has nothing to send.
  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    tcnt_d    = tcnt_q;
    if (xfer) begin
      tcnt_d    = '0;
      lock_d    = (din != UART_NL);
      lock_id_d = win;
    end else if (lock_q && idle && txclk_en &&
                 !(|(req_valid & lock_mask))) begin
      if (tcnt_q == 32'(LOCK_TIMEOUT - 1)) begin
        lock_d = 1'b0;
        tcnt_d = '0;
      end else begin
        tcnt_d = tcnt_q + 32'd1;
      end
    end
  end
`else
  logic unused_cfg;

  assign cand       = req_valid;
  assign unused_cfg = ^LOCK_TIMEOUT;
`endif

  // Search starts one past the last grant and wraps modulo NREQ.
  always_comb begin
    int idx;
    win     = '0;
    win_vld = 1'b0;
    idx     = 0;
    for (int k = 1; k <= UART_MAX_REQ; k++) begin
      if (k <= NREQ) begin
        idx = (int'(last_q) + k) % NREQ;
        for (int i = 0; i < NREQ; i++) begin
          if (!win_vld && i == idx && cand[i]) begin
            win_vld = 1'b1;
            win     = 3'(i);
          end
        end
      end
    end
  end

  always_comb begin
    din = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == 3'(i)) din = req_data[8*i +: 8];
    end
  end

  assign idle = !rst && !ser_busy;
  assign xfer = idle && win_vld;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = xfer && (win == 3'(i));
    end
  end

  always_comb begin
    last_d  = last_q;
    grant_d = grant_q;
    if (xfer) begin
      last_d  = win;
      grant_d = win;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q  <= 3'(NREQ - 1);
      grant_q <= '0;
    end else begin
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end

  uart_tx_serializer u_ser (
    .clk      (clk),
    .rst      (rst),
    .txclk_en (txclk_en),
    .load     (xfer),
    .din      (din),
    .tx       (tx),
    .busy     (ser_busy)
  );

  assign busy     = ser_busy;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: frame-level model plus directed literal pins.
// Line-lock expectations follow UART_ARB_LINE_LOCK_EN when defined.
module tb_uart_tx_arbiter;

  localparam int NREQ = 2;
  localparam int LT   = 4;
`ifdef UART_ARB_LINE_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              txclk_en;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              tx;
  logic              busy;
  logic [2:0]        grant_id;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .LOCK_TIMEOUT(LT)) dut (
    .clk       (clk),
    .rst       (rst),
    .txclk_en  (txclk_en),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx        (tx),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: a frame is "strobes seen since accept"; tx is the frame bit at that count.
  bit         m_busy;
  int         m_n;
  logic [7:0] m_byte;
  int         m_last;
  int         m_grant;
  bit         m_lock;
  int         m_lock_id;
  int         m_cnt;

  logic [7:0] rq[NREQ][$];
  bit         pause[NREQ];
  int         dut_acc[$];
  int         ctr;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int model_winner();
    int idx;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (m_last + k) % NREQ;
      if (req_valid[idx] && (!m_lock || idx == m_lock_id)) return idx;
    end
    return -1;
  endfunction

  function automatic logic exp_tx();
    if (!m_busy || m_n == 0 || m_n >= 10) return 1'b1;
    if (m_n == 1) return 1'b0;
    return m_byte[m_n-2];
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]       = (rq[i].size() > 0) && !pause[i];
      req_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
    end
  endtask

  task automatic step(input bit en);
    int w;
    logic [NREQ-1:0] er;
    txclk_en = en;
    drive_inputs();
    #1;
    w  = model_winner();
    er = '0;
    if (!rst && !m_busy && w >= 0) er[w] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(er));
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) dut_acc.push_back(i);
    end
    @(posedge clk);
    if (rst) begin
      m_busy  = 1'b0;
      m_n     = 0;
      m_last  = NREQ - 1;
      m_grant = 0;
      m_lock  = 1'b0;
      m_cnt   = 0;
    end else if (!m_busy) begin
      if (w >= 0) begin
        m_byte  = rq[w][0];
        m_busy  = 1'b1;
        m_n     = 0;
        m_last  = w;
        m_grant = w;
        m_cnt   = 0;
        if (LOCK) begin
          m_lock    = (m_byte != 8'h0A);
          m_lock_id = w;
        end
        void'(rq[w].pop_front());
      end else if (LOCK && m_lock && !req_valid[m_lock_id] && en) begin
        m_cnt++;
        if (m_cnt == LT) begin
          m_lock = 1'b0;
          m_cnt  = 0;
        end
      end
    end else if (en) begin
      m_n++;
      if (m_n == 11) m_busy = 1'b0;
    end
    #1;
    check("tx", 32'(tx), 32'(exp_tx()));
    check("busy", 32'(busy), 32'(m_busy));
    check("grant_id", 32'(grant_id), 32'(m_grant));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
  endtask

  task automatic drain(input int period, input int budget);
    int c;
    c = 0;
    while ((m_busy || rq[0].size() > 0 || rq[1].size() > 0) && c < budget) begin
      step(ctr % period == 0);
      ctr++;
      c++;
    end
    check("drain_timeout", 32'(c < budget), 32'd1);
  endtask

  initial begin
    logic [9:0] cap;
    int         j;
    int         c;
    int         idle_strobes;
    int         exp_ord[4];

    rst       = 1'b1;
    txclk_en  = 1'b0;
    req_valid = '0;
    req_data  = '0;
    for (int i = 0; i < NREQ; i++) pause[i] = 1'b0;
    m_lock_id = 0;
    m_byte    = '0;
    @(negedge clk);

    // Reset with a requester valid: nothing accepted.
    rq[0].push_back(8'h55);
    step(1'b0);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    rst = 1'b0;

    // Single 0x55 frame, strobe every 4 cycles.
    ctr = 1;
    c   = 0;
    while (!busy && c < 20) begin
      step(ctr % 4 == 0);
      ctr++;
      c++;
    end
    check("accept_timeout", 32'(busy), 32'd1);
    cap = '0;
    j   = 0;
    for (int k = 0; k < 80 && j < 11; k++) begin
      bit e;
      e = (ctr % 4 == 0);
      ctr++;
      step(e);
      if (e) begin
        if (j < 10) cap[j] = tx;
        j++;
        if (j == 11) check("busy_after_stop", 32'(busy), 32'd0);
      end
    end
    check("frame_0x55", 32'(cap), 32'(10'b1010101010));
    check("single_grant", 32'(grant_id), 32'd0);

    // Fairness from reset.
    do_reset();
    dut_acc.delete();
    for (int k = 0; k < 4; k++) begin
      rq[0].push_back(8'h41);
      rq[1].push_back(8'h42);
    end
    ctr = 1;
    drain(2, 400);
    exp_ord = '{0, 1, 0, 1};
    for (int k = 0; k < 4; k++) begin
      check($sformatf("fair_ord%0d", k),
            32'(dut_acc.size() > k ? dut_acc[k] : -1), 32'(exp_ord[k]));
    end

    // Strobe in the accept cycle is ignored.
    rq[0].push_back(8'h3C);
    step(1'b1);
    check("coin_busy", 32'(busy), 32'd1);
    check("coin_tx0", 32'(tx), 32'd1);
    step(1'b0);
    step(1'b0);
    check("coin_tx1", 32'(tx), 32'd1);
    step(1'b1);
    check("coin_fall", 32'(tx), 32'd0);
    ctr = 1;
    drain(3, 200);

    // Reset in the middle of DATA, after bit 3.
    rq[1].push_back(8'hA5);
    c = 0;
    while (!(m_busy && m_n == 5) && c < 100) begin
      step(ctr % 2 == 0);
      ctr++;
      c++;
    end
    check("mid_timeout", 32'(c < 100), 32'd1);
    do_reset();
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_grant", 32'(grant_id), 32'd0);
    dut_acc.delete();
    rq[0].push_back(8'h22);
    rq[1].push_back(8'h11);
    step(1'b0);
    check("post_rst_win", 32'(dut_acc.size() > 0 ? dut_acc[0] : -1), 32'd0);
    ctr = 1;
    drain(2, 400);

    // Line lock ordering.
    do_reset();
    dut_acc.delete();
    rq[0].push_back(8'h61);
    rq[0].push_back(8'h62);
    rq[0].push_back(8'h0A);
    rq[1].push_back(8'h78);
    rq[1].push_back(8'h79);
    ctr = 1;
    drain(2, 600);
    exp_ord = LOCK ? '{0, 0, 0, 1} : '{0, 1, 0, 1};
    for (int k = 0; k < 4; k++) begin
      check($sformatf("lock_ord%0d", k),
            32'(dut_acc.size() > k ? dut_acc[k] : -1), 32'(exp_ord[k]));
    end

    // Lock timeout: count idle strobes before req1 gets in.
    do_reset();
    dut_acc.delete();
    rq[0].push_back(8'h61);
    step(1'b0);
    rq[1].push_back(8'h7A);
    ctr          = 1;
    idle_strobes = 0;
    c            = 0;
    while (dut_acc.size() < 2 && c < 300) begin
      bit e;
      e = (ctr % 3 == 0);
      ctr++;
      if (e && !busy) idle_strobes++;
      step(e);
      c++;
    end
    check("lock_tmo_acc", 32'(dut_acc.size() > 1 ? dut_acc[1] : -1), 32'd1);
    check("lock_tmo_strobes", 32'(idle_strobes), LOCK ? 32'(LT) : 32'd0);
    drain(3, 200);

    // Randomised traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 7) == 0 && rq[i].size() < 4) begin
          rq[i].push_back($urandom_range(0, 3) == 0 ? 8'h0A
                                                    : 8'($urandom));
        end
        if ($urandom_range(0, 9) == 0) pause[i] = !pause[i];
      end
      rst = ($urandom_range(0, 999) == 0);
      step($urandom_range(0, 99) < 35);
    end
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) pause[i] = 1'b0;
    ctr = 1;
    drain(2, 2000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
